dsc_mul_ctrl: RTL and testbench
===============================

Name: dsc_mul_ctrl

Overview:
Operand sequencer and result-capture stage wrapped around the 4-input deterministic stochastic multiplier (dsc_mul).
- Upstream: accepts one operand tuple per valid/ready transfer and holds it stable on the multiplier inputs.
- Run control: clears the multiplier and enables it, then waits for the multiplier overflow/early-shutoff flag.
- Downstream: captures the raw binary count, derives a SNG_WIDTH-bit normalized product, and presents both through a valid/ready result port.

Parameters:
- SNG_WIDTH, 10, operand width and normalized result width.
- NUM_INPUTS, 4, operand count; raw result width is NUM_INPUTS*SNG_WIDTH.
- CYC_WIDTH, 16, width of the saturating run-cycle counter.
- TMO_WIDTH, 20, timeout counter width (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand tuple valid.
- in_ready  out  1  controller can accept a tuple.
- in_a, in_b, in_c, in_d  in  SNG_WIDTH each  operands.
- mul_a, mul_b, mul_c, mul_d  out  SNG_WIDTH each  latched operands to the multiplier.
- mul_rst  out  1  multiplier clear, active-high.
- mul_en  out  1  multiplier enable.
- mul_z  in  NUM_INPUTS*SNG_WIDTH  multiplier raw count.
- mul_ov  in  1  multiplier done (overflow or early shutoff).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_z  out  NUM_INPUTS*SNG_WIDTH  captured raw count.
- out_q  out  SNG_WIDTH  normalized product.
- out_cycles  out  CYC_WIDTH  RUN-cycle count of the operation.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, except mul_rst = 1 (multiplier held cleared).
- The FSM has five states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - in_ready = 1; mul_rst = 1; mul_en = 0.
  - On in_valid & in_ready: latch in_a..in_d into mul_a..mul_d, zero the cycle counter, go to CLEAR.
- CLEAR (exactly 1 cycle): mul_rst = 1, mul_en = 0; go to RUN.
- RUN:
  - mul_rst = 0, mul_en = 1.
  - The cycle counter increments every RUN cycle and saturates at all-ones.
  - mul_ov is sampled every RUN cycle, including the first. Sampled high: go to DRAIN.
- DRAIN (exactly 1 cycle):
  - mul_en = 0, so the final count increment lands.
  - At the end of DRAIN, capture out_z = mul_z and out_q = mul_z >> ((NUM_INPUTS-1)*SNG_WIDTH), which is the truncated upper SNG_WIDTH bits.
  - Go to DONE.
- DONE:
  - out_valid = 1; out_z, out_q and out_cycles are held stable.
  - On out_valid & out_ready: out_valid drops next cycle and the state returns to IDLE.
  - The earliest next input acceptance is the cycle after the return to IDLE.
- Timing: operand latches and mul_a..mul_d change only on accepted transfers. out_* change only at the DRAIN capture.
- Minimum latency, acceptance edge to out_valid high: 4 cycles, when mul_ov is already high in the first RUN cycle.
- in_valid outside IDLE is ignored (in_ready = 0), with no side effects.
- out_ready while out_valid = 0 is ignored.
- Reset asserted mid-operation: outputs and state return to reset values immediately. Any in-flight result is discarded and no out_valid is produced.
- mul_z is treated as unsigned. No arithmetic is performed beyond the shift.

Optional Feature:
DSC_MUL_CTRL_TIMEOUT_EN
- Enabled:
  - Adds a TMO_WIDTH-bit RUN-cycle counter and an output port out_err (1 bit, reset 0).
  - If RUN lasts 2^TMO_WIDTH cycles without mul_ov, go to DRAIN and capture normally, with out_err = 1.
  - out_err is held through DONE and cleared at the next acceptance.
- Disabled: no timeout counter, no out_err port, and RUN waits indefinitely for mul_ov.

Test Plan:
The bench uses a behavioural multiplier model that asserts mul_ov after N enabled cycles with a programmed mul_z.
1. Basic: accept a=3,b=5,c=7,d=9; model N=5, mul_z=40'h00C0000005 -> mul_a..d = 3,5,7,9 during RUN; out_valid at the acceptance edge + 8 cycles; out_z = 40'h00C0000005, out_q = 3, out_cycles = 5.
2. Immediate shutoff: d=0, model holds mul_ov=1, mul_z=0 -> out_valid 4 cycles after acceptance; out_q = 0, out_cycles = 1.
3. Backpressure: out_ready = 0 for 10 cycles in DONE -> out_valid and out_* stable, in_ready = 0, a second in_valid is ignored; out_ready = 1 -> IDLE next cycle, then the second tuple is accepted.
4. Reset mid-RUN: drop rst at RUN cycle 3 -> immediate mul_rst=1, mul_en=0, busy=0, out_valid=0; after release, a new tuple completes normally.
5. Saturation: model N = 70000 with CYC_WIDTH=16 -> out_cycles = 16'hFFFF.
6. Timeout (DSC_MUL_CTRL_TIMEOUT_EN, TMO_WIDTH=4): model never asserts mul_ov -> DRAIN after 16 RUN cycles, out_err = 1, out_valid asserted; the next tuple clears out_err.

Source files
------------

// File: rtl/dsc_mul_ctrl_if.sv
// dsc_mul_ctrl_if: bundles the controller's handshake and multiplier signals.
//   upstream   : in_valid/in_ready, in_a..in_d
//   multiplier : mul_a..mul_d, mul_rst, mul_en, mul_z, mul_ov
//   downstream : out_valid/out_ready, out_z, out_q, out_cycles (+ out_err)
//   status     : busy
// Modports: slave = the controller, master = its environment.
// DSC_MUL_CTRL_TIMEOUT_EN adds out_err.
interface dsc_mul_ctrl_if #(
  parameter int unsigned SNG_WIDTH  = 10,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned CYC_WIDTH  = 16
);
  localparam int unsigned ZW = NUM_INPUTS * SNG_WIDTH;

  logic                 in_valid;
  logic                 in_ready;
  logic [SNG_WIDTH-1:0] in_a, in_b, in_c, in_d;
  logic [SNG_WIDTH-1:0] mul_a, mul_b, mul_c, mul_d;
  logic                 mul_rst;
  logic                 mul_en;
  logic [ZW-1:0]        mul_z;
  logic                 mul_ov;
  logic                 out_valid;
  logic                 out_ready;
  logic [ZW-1:0]        out_z;
  logic [SNG_WIDTH-1:0] out_q;
  logic [CYC_WIDTH-1:0] out_cycles;
  logic                 busy;
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
  logic                 out_err;
`endif

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, mul_z, mul_ov, out_ready,
    output in_ready, mul_a, mul_b, mul_c, mul_d, mul_rst, mul_en,
    output out_valid, out_z, out_q, out_cycles, busy
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
    , output out_err
`endif
  );

  modport master (
    output in_valid, in_a, in_b, in_c, in_d, mul_z, mul_ov, out_ready,
    input  in_ready, mul_a, mul_b, mul_c, mul_d, mul_rst, mul_en,
    input  out_valid, out_z, out_q, out_cycles, busy
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
    , input out_err
`endif
  );
endinterface

// File: rtl/dsc_mul_ctrl.sv
// dsc_mul_ctrl: operand sequencer and result capture around the stochastic
// multiplier. Accepts an operand tuple, clears then runs the multiplier until
// mul_ov, captures the raw count plus its upper SNG_WIDTH bits, and holds the
// result on a valid/ready port.
// Ports: clk; rst (async, active-low); bus (dsc_mul_ctrl_if.slave) carrying
//   in_* (operand handshake), mul_* (multiplier drive/response),
//   out_* (result handshake) and busy.
// Optional macro DSC_MUL_CTRL_TIMEOUT_EN: RUN gives up after 2^TMO_WIDTH
//   cycles without mul_ov and flags the result with out_err.
module dsc_mul_ctrl #(
  parameter int unsigned SNG_WIDTH  = 10,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned CYC_WIDTH  = 16
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TMO_WIDTH  = 20
`endif
) (
  input  logic          clk,
  input  logic          rst,
  dsc_mul_ctrl_if.slave bus
);

  localparam int unsigned ZW  = NUM_INPUTS * SNG_WIDTH;
  localparam int unsigned QSH = (NUM_INPUTS - 1) * SNG_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [SNG_WIDTH-1:0] op_a_q, op_b_q, op_c_q, op_d_q;
  logic [SNG_WIDTH-1:0] op_a_d, op_b_d, op_c_d, op_d_d;
  logic [CYC_WIDTH-1:0] cyc_q, cyc_d;
  logic [ZW-1:0]        out_z_q, out_z_d;
  logic [SNG_WIDTH-1:0] out_q_q, out_q_d;
  logic [CYC_WIDTH-1:0] out_cycles_q, out_cycles_d;
  logic                 in_ready_q, in_ready_d;
  logic                 mul_rst_q, mul_rst_d;
  logic                 mul_en_q, mul_en_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
  logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
  logic                 tmo_hit_q, tmo_hit_d;
  logic                 out_err_q, out_err_d;
`endif

  // Next state, datapath updates, and control outputs decoded from state_d
  // so every output is a flop aligned with the state it belongs to.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_c_d       = op_c_q;
    op_d_d       = op_d_q;
    cyc_d        = cyc_q;
    out_z_d      = out_z_q;
    out_q_d      = out_q_q;
    out_cycles_d = out_cycles_q;
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
    tmo_d        = tmo_q;
    tmo_hit_d    = tmo_hit_q;
    out_err_d    = out_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          op_a_d  = bus.in_a;
          op_b_d  = bus.in_b;
          op_c_d  = bus.in_c;
          op_d_d  = bus.in_d;
          cyc_d   = '0;
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
          tmo_d     = '0;
          tmo_hit_d = 1'b0;
          out_err_d = 1'b0;
`endif
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + CYC_WIDTH'(1);
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
        tmo_d = tmo_q + TMO_WIDTH'(1);
`endif
        if (bus.mul_ov) begin
          state_d = S_DRAIN;
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
        end else if (tmo_q == '1) begin
          // Last allowed RUN cycle passed without mul_ov.
          tmo_hit_d = 1'b1;
          state_d   = S_DRAIN;
`endif
        end
      end
      S_DRAIN: begin
        // Multiplier is disabled here, so mul_z already holds the final count.
        out_z_d      = bus.mul_z;
        out_q_d      = SNG_WIDTH'(bus.mul_z >> QSH);
        out_cycles_d = cyc_q;
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
        out_err_d    = tmo_hit_q;
`endif
        state_d      = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready && out_valid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    mul_rst_d   = (state_d == S_IDLE) || (state_d == S_CLEAR);
    mul_en_d    = (state_d == S_RUN);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_c_q       <= '0;
      op_d_q       <= '0;
      cyc_q        <= '0;
      out_z_q      <= '0;
      out_q_q      <= '0;
      out_cycles_q <= '0;
      in_ready_q   <= 1'b0;
      mul_rst_q    <= 1'b1;
      mul_en_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
      tmo_q        <= '0;
      tmo_hit_q    <= 1'b0;
      out_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_c_q       <= op_c_d;
      op_d_q       <= op_d_d;
      cyc_q        <= cyc_d;
      out_z_q      <= out_z_d;
      out_q_q      <= out_q_d;
      out_cycles_q <= out_cycles_d;
      in_ready_q   <= in_ready_d;
      mul_rst_q    <= mul_rst_d;
      mul_en_q     <= mul_en_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
      tmo_q        <= tmo_d;
      tmo_hit_q    <= tmo_hit_d;
      out_err_q    <= out_err_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mul_a      = op_a_q;
  assign bus.mul_b      = op_b_q;
  assign bus.mul_c      = op_c_q;
  assign bus.mul_d      = op_d_q;
  assign bus.mul_rst    = mul_rst_q;
  assign bus.mul_en     = mul_en_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_z      = out_z_q;
  assign bus.out_q      = out_q_q;
  assign bus.out_cycles = out_cycles_q;
  assign bus.busy       = busy_q;
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
  assign bus.out_err    = out_err_q;
`endif

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// Self-checking bench for dsc_mul_ctrl: behavioural multiplier stand-in,
// transaction-level reference model, per-cycle compare, directed and random ops.
module tb_dsc_mul_ctrl;
  localparam int unsigned SW = 10;
  localparam int unsigned NI = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned ZW = NI * SW;
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = 4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsc_mul_ctrl_if #(.SNG_WIDTH(SW), .NUM_INPUTS(NI), .CYC_WIDTH(CW)) bus ();

  dsc_mul_ctrl #(
    .SNG_WIDTH(SW), .NUM_INPUTS(NI), .CYC_WIDTH(CW)
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
    , .TMO_WIDTH(TMO_W)
`endif
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Multiplier stand-in: mul_ov rises in the n_cfg-th enabled cycle.
  int unsigned     n_cfg = 1;
  logic            hold_ov = 1'b0;
  logic [ZW-1:0]   z_cfg = '0;
  int unsigned     en_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           en_cnt <= 0;
    else if (bus.mul_rst) en_cnt <= 0;
    else if (bus.mul_en)  en_cnt <= en_cnt + 1;
  end
  assign bus.mul_ov = hold_ov | (bus.mul_en & ((en_cnt + 1) >= n_cfg));
  assign bus.mul_z  = z_cfg;

  // Number of RUN cycles an operation takes, and whether it times out.
  function automatic int unsigned run_len(input int unsigned n, input logic hold);
    int unsigned k;
    k = hold ? 1 : n;
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
    if (k > (1 << TMO_W)) k = (1 << TMO_W);
`endif
    return k;
  endfunction

  function automatic logic run_err(input int unsigned n, input logic hold);
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
    return !hold && (n > (1 << TMO_W));
`else
    return 1'b0 & hold & (n == 0);
`endif
  endfunction

  // Reference model: one transaction timeline, el = edges since acceptance.
  logic          m_ready, m_busy, m_valid, m_err, m_kerr;
  int unsigned   m_el, m_k;
  logic [SW-1:0] m_a, m_b, m_c, m_d, m_q;
  logic [ZW-1:0] m_z;
  logic [CW-1:0] m_cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b0; m_busy <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0; m_kerr <= 1'b0;
      m_el <= 0; m_k <= 0;
      m_a <= '0; m_b <= '0; m_c <= '0; m_d <= '0;
      m_z <= '0; m_q <= '0; m_cyc <= '0;
    end else if (!m_busy) begin
      m_ready <= 1'b1;
      if (m_ready && bus.in_valid) begin
        m_ready <= 1'b0;
        m_busy  <= 1'b1;
        m_el    <= 0;
        m_a <= bus.in_a; m_b <= bus.in_b; m_c <= bus.in_c; m_d <= bus.in_d;
        m_k     <= run_len(n_cfg, hold_ov);
        m_kerr  <= run_err(n_cfg, hold_ov);
        m_err   <= 1'b0;
      end
    end else begin
      m_el <= m_el + 1;
      if (m_valid) begin
        if (bus.out_ready) begin
          m_valid <= 1'b0;
          m_busy  <= 1'b0;
          m_ready <= 1'b1;
        end
      end else if (m_el + 1 == m_k + 2) begin
        m_valid <= 1'b1;
        m_z     <= z_cfg;
        m_q     <= SW'(z_cfg >> ((NI - 1) * SW));
        m_cyc   <= (m_k > 65535) ? CW'(65535) : CW'(m_k);
        m_err   <= m_kerr;
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready",   64'(bus.in_ready),  64'(m_ready));
      chk("busy",       64'(bus.busy),      64'(m_busy));
      chk("out_valid",  64'(bus.out_valid), 64'(m_valid));
      chk("mul_en",     64'(bus.mul_en),    64'(m_busy && m_el >= 1 && m_el <= m_k));
      chk("mul_rst",    64'(bus.mul_rst),   64'(!m_busy || m_el == 0));
      chk("mul_a",      64'(bus.mul_a),     64'(m_a));
      chk("mul_b",      64'(bus.mul_b),     64'(m_b));
      chk("mul_c",      64'(bus.mul_c),     64'(m_c));
      chk("mul_d",      64'(bus.mul_d),     64'(m_d));
      chk("out_z",      64'(bus.out_z),     64'(m_z));
      chk("out_q",      64'(bus.out_q),     64'(m_q));
      chk("out_cycles", 64'(bus.out_cycles), 64'(m_cyc));
`ifdef DSC_MUL_CTRL_TIMEOUT_EN
      chk("out_err",    64'(bus.out_err),   64'(m_err));
`endif
    end
  end

  // out_ready driver: 0 random, 1 held low, 2 held high.
  int rdy_mode = 0;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        1:       bus.out_ready = 1'b0;
        2:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Present a tuple and return at the negedge after the acceptance edge.
  task automatic start_op(input logic [SW-1:0] a, b, c, d, input int unsigned n,
                          input logic hold, input logic [ZW-1:0] z);
    int guard;
    guard = 0;
    @(negedge clk);
    n_cfg = n; hold_ov = hold; z_cfg = z;
    bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_d = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) bound_fail("accept_wait");
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid; lat counts edges from the acceptance edge, inclusive.
  // Junk in_valid pulses while busy must be ignored.
  task automatic wait_valid(input int limit, output int lat);
    lat = 1;
    while (!bus.out_valid && lat < limit) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a = SW'($urandom); bus.in_b = SW'($urandom);
      bus.in_c = SW'($urandom); bus.in_d = SW'($urandom);
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) bound_fail("valid_wait");
  endtask

  task automatic finish_op();
    int guard;
    guard = 0;
    while (bus.out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (bus.out_valid) bound_fail("handshake_wait");
  endtask

  initial begin
    int lat;
    int unsigned n;
    logic hold;
    logic [ZW-1:0] z;

    bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0;
    repeat (3) @(negedge clk);
    chk("reset_mul_rst",   64'(bus.mul_rst),   64'd1);
    chk("reset_in_ready",  64'(bus.in_ready),  64'd0);
    chk("reset_busy",      64'(bus.busy),      64'd0);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_z",     64'(bus.out_z),     64'd0);
    rst_n = 1'b1;

    // 1. Basic operation
    start_op(10'd3, 10'd5, 10'd7, 10'd9, 5, 1'b0, 40'h00C0000005);
    chk("t1_mul_a", 64'(bus.mul_a), 64'd3);
    chk("t1_mul_d", 64'(bus.mul_d), 64'd9);
    wait_valid(100, lat);
    chk("t1_latency",    64'(lat),            64'd8);
    chk("t1_out_z",      64'(bus.out_z),      64'h00C0000005);
    chk("t1_out_q",      64'(bus.out_q),      64'd3);
    chk("t1_out_cycles", 64'(bus.out_cycles), 64'd5);
    finish_op();

    // 2. Immediate shutoff
    start_op(10'd100, 10'd200, 10'd300, 10'd0, 1, 1'b1, 40'h0);
    wait_valid(100, lat);
    chk("t2_latency",    64'(lat),            64'd4);
    chk("t2_out_q",      64'(bus.out_q),      64'd0);
    chk("t2_out_cycles", 64'(bus.out_cycles), 64'd1);
    finish_op();

    // 3. Backpressure, ignored second tuple, then accepted after return to IDLE
    rdy_mode = 1;
    start_op(10'd11, 10'd22, 10'd33, 10'd44, 3, 1'b0, 40'hFFC0000001);
    wait_valid(100, lat);
    chk("t3_out_q", 64'(bus.out_q), 64'h3FF);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        n_cfg = 2; hold_ov = 1'b0; z_cfg = 40'h1234567890;
        bus.in_a = 10'd401; bus.in_b = 10'd402; bus.in_c = 10'd403; bus.in_d = 10'd404;
        bus.in_valid = 1'b1;
      end
      @(negedge clk);
      chk("t3_stall_in_ready",  64'(bus.in_ready),  64'd0);
      chk("t3_stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("t3_stall_mul_a",     64'(bus.mul_a),     64'd11);
    end
    rdy_mode = 2;
    begin
      int g;
      g = 0;
      while (bus.out_valid && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (bus.out_valid) bound_fail("t3_release");
    end
    chk("t3_idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t3_idle_busy",     64'(bus.busy),     64'd0);
    @(negedge clk);
    chk("t3_second_busy",  64'(bus.busy),  64'd1);
    chk("t3_second_mul_a", 64'(bus.mul_a), 64'd401);
    bus.in_valid = 1'b0;
    wait_valid(100, lat);
    chk("t3_second_out_q", 64'(bus.out_q), 64'h048);
    finish_op();
    rdy_mode = 0;

    // 4. Reset in the third RUN cycle
    start_op(10'd1, 10'd2, 10'd3, 10'd4, 20, 1'b0, 40'hABCDE12345);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_mul_rst",   64'(bus.mul_rst),   64'd1);
    chk("t4_mul_en",    64'(bus.mul_en),    64'd0);
    chk("t4_busy",      64'(bus.busy),      64'd0);
    chk("t4_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_mul_a",     64'(bus.mul_a),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(10'd7, 10'd8, 10'd9, 10'd10, 6, 1'b0, 40'h4000000000);
    wait_valid(100, lat);
    chk("t4_after_latency", 64'(lat),       64'(run_len(6, 1'b0) + 3));
    chk("t4_after_out_q",   64'(bus.out_q), 64'h100);
    finish_op();

`ifndef DSC_MUL_CTRL_TIMEOUT_EN
    // 5. Cycle counter saturation
    start_op(10'd5, 10'd5, 10'd5, 10'd5, 70000, 1'b0, 40'h0000000001);
    wait_valid(80000, lat);
    chk("t5_out_cycles", 64'(bus.out_cycles), 64'hFFFF);
    chk("t5_latency",    64'(lat),            64'd70003);
    finish_op();
`else
    // 6. Timeout with TMO_WIDTH = 4
    start_op(10'd5, 10'd6, 10'd7, 10'd8, 32'hFFFF_FFFF, 1'b0, 40'h00C0000000);
    wait_valid(100, lat);
    chk("t6_latency",    64'(lat),            64'd19);
    chk("t6_out_err",    64'(bus.out_err),    64'd1);
    chk("t6_out_cycles", 64'(bus.out_cycles), 64'd16);
    chk("t6_out_q",      64'(bus.out_q),      64'd3);
    finish_op();
    start_op(10'd1, 10'd1, 10'd1, 10'd1, 2, 1'b0, 40'h0);
    chk("t6_err_cleared", 64'(bus.out_err), 64'd0);
    wait_valid(100, lat);
    chk("t6_next_err", 64'(bus.out_err), 64'd0);
    finish_op();
`endif

    // Random operations
    for (int i = 0; i < 25; i++) begin
      n    = $urandom_range(1, 30);
      hold = ($urandom_range(0, 7) == 0);
      z    = ZW'({$urandom, $urandom});
      start_op(SW'($urandom), SW'($urandom), SW'($urandom), SW'($urandom), n, hold, z);
      wait_valid(200, lat);
      chk("rand_latency", 64'(lat), 64'(run_len(n, hold) + 3));
      finish_op();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
